// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: datapath word, byte write mask and the
// memory-port arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/register.sv
// Generic loadable register with synchronous active-low clear.
module register #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [width-1:0] in_i,
  output logic [width-1:0] out_o
);

  always_ff @(posedge clk) begin
    if (!reset_n) out_o <= '0;
    else if (load_i) out_o <= in_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises LC-3b fetch (imem) and data (dmem) requests onto one physical
// memory port; data has priority, bounded by a starvation counter for fetch.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          imem_read,
  input  lc3b_word      imem_address,
  output lc3b_word      imem_rdata,
  output logic          imem_resp,
  input  logic          dmem_read,
  input  logic          dmem_write,
  input  lc3b_word      dmem_address,
  input  lc3b_word      dmem_wdata,
  input  lc3b_mem_wmask dmem_byte_enable,
  output lc3b_word      dmem_rdata,
  output logic          dmem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp,
  output arb_state_t    dbg_state_o,
  output logic [CNT_W-1:0] dbg_starve_cnt_o
);

  // Handshake: a client raises read/write and holds it (with address/data
  // stable) until its resp pulse; resp lasts one cycle and rdata is only
  // meaningful in that cycle. pmem strobes likewise hold until pmem_resp.

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          dreq, d_wins, grant_d, grant_i, cap_load, serving, rdata_load;
  lc3b_word      cap_addr_d, cap_wdata_d, addr_q, wdata_q, rdata_q;
  lc3b_mem_wmask cap_be_d, be_q;
  logic          cap_wr_d, wr_q;

  assign dreq    = dmem_read | dmem_write;
  assign d_wins  = dreq && (!imem_read || (cnt_q < LIMIT));
  assign grant_d = (state_q == IDLE) && d_wins;
  assign grant_i = (state_q == IDLE) && !d_wins && imem_read;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  // Write wins when a client raises read and write together.
  assign cap_load    = grant_d | grant_i;
  assign cap_addr_d  = grant_d ? dmem_address     : imem_address;
  assign cap_wdata_d = grant_d ? dmem_wdata       : '0;
  assign cap_be_d    = grant_d ? dmem_byte_enable : 2'b11;
  assign cap_wr_d    = grant_d & dmem_write;
  assign rdata_load  = serving & pmem_resp;

  register #(.width(16)) u_addr  (.clk(clk), .reset_n(reset_n), .load_i(cap_load),
                                  .in_i(cap_addr_d),  .out_o(addr_q));
  register #(.width(16)) u_wdata (.clk(clk), .reset_n(reset_n), .load_i(cap_load),
                                  .in_i(cap_wdata_d), .out_o(wdata_q));
  register #(.width(2))  u_be    (.clk(clk), .reset_n(reset_n), .load_i(cap_load),
                                  .in_i(cap_be_d),    .out_o(be_q));
  register #(.width(1))  u_op    (.clk(clk), .reset_n(reset_n), .load_i(cap_load),
                                  .in_i(cap_wr_d),    .out_o(wr_q));
  register #(.width(16)) u_rdata (.clk(clk), .reset_n(reset_n), .load_i(rdata_load),
                                  .in_i(pmem_rdata),  .out_o(rdata_q));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          if (!imem_read)          cnt_d = '0;
          else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (grant_i) begin
          state_d = SERVE_I;
          cnt_d   = '0;
        end
      end
      SERVE_I: if (pmem_resp) state_d = RESP_I;
      SERVE_D: if (pmem_resp) state_d = RESP_D;
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Physical port is quiet outside SERVE so reset and idle both read as zero.
  assign pmem_read        = serving & ~wr_q;
  assign pmem_write       = serving & wr_q;
  assign pmem_address     = serving ? addr_q  : '0;
  assign pmem_wdata       = serving ? wdata_q : '0;
  assign pmem_byte_enable = serving ? (wr_q ? be_q : 2'b11) : 2'b00;

  assign imem_resp  = (state_q == RESP_I);
  assign dmem_resp  = (state_q == RESP_D);
  assign imem_rdata = rdata_q;
  assign dmem_rdata = rdata_q;

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized request
// rounds checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  import lc3b_types::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic imem_read, dmem_read, dmem_write, pmem_resp;
  logic [15:0] imem_address, dmem_address, dmem_wdata, pmem_rdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] imem_rdata, dmem_rdata, pmem_address, pmem_wdata;
  logic        imem_resp, dmem_resp, pmem_read, pmem_write;
  logic [1:0]  pmem_byte_enable;
  arb_state_t  dbg_state;
  logic [2:0]  dbg_cnt;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd"},   16'(pmem_read),  16'd0);
    check({tag, "_wr"},   16'(pmem_write), 16'd0);
    check({tag, "_iresp"}, 16'(imem_resp), 16'd0);
    check({tag, "_dresp"}, 16'(dmem_resp), 16'd0);
  endtask

  // One arbitration round, entered and left at the falling edge of an IDLE cycle.
  // Returns winner: 0 none, 1 imem, 2 dmem.
  task automatic do_round(input logic ir, input logic [15:0] ia,
                          input logic dr, input logic dw, input logic [15:0] da,
                          input logic [15:0] wd, input logic [1:0] be,
                          input int wt, input logic [15:0] rd, output int w);
    logic        e_wr;
    logic [15:0] e_addr, e_wd, got;
    logic [1:0]  e_be;
    check_quiet("idle");
    check("idle_state", 16'(dbg_state), 16'(IDLE));
    imem_read = ir; imem_address = ia;
    dmem_read = dr; dmem_write = dw; dmem_address = da;
    dmem_wdata = wd; dmem_byte_enable = be;

    if ((dr || dw) && (!ir || m_cnt < LIMIT)) begin
      w = 2;
      m_cnt = ir ? ((m_cnt < 7) ? m_cnt + 1 : 7) : 0;
      e_wr = dw; e_addr = da; e_wd = wd; e_be = dw ? be : 2'b11;
    end else if (ir) begin
      w = 1; m_cnt = 0;
      e_wr = 1'b0; e_addr = ia; e_wd = 16'd0; e_be = 2'b11;
    end else begin
      w = 0; e_wr = 1'b0; e_addr = 16'd0; e_wd = 16'd0; e_be = 2'b00;
    end

    if (w == 0) begin
      pmem_resp = 1'b1;
      pmem_rdata = 16'($urandom);
      @(negedge clk);
      pmem_resp = 1'b0;
      check_quiet("stray_idle");
      return;
    end

    for (int i = 0; i <= wt; i++) begin
      @(negedge clk);
      check("srv_rd",   16'(pmem_read),  16'(!e_wr));
      check("srv_wr",   16'(pmem_write), 16'(e_wr));
      check("srv_addr", pmem_address, e_addr);
      check("srv_be",   16'(pmem_byte_enable), 16'(e_be));
      if (e_wr) check("srv_wdata", pmem_wdata, e_wd);
      check("srv_cnt",  16'(dbg_cnt), 16'(m_cnt));
      check("srv_iresp", 16'(imem_resp), 16'd0);
      check("srv_dresp", 16'(dmem_resp), 16'd0);
      if (i == wt) begin
        pmem_resp = 1'b1; pmem_rdata = rd;
        exp_q.push_back(rd);
      end
    end

    @(negedge clk);
    pmem_resp = $urandom_range(0, 1);
    pmem_rdata = 16'($urandom);
    check("resp_i", 16'(imem_resp), 16'(w == 1));
    check("resp_d", 16'(dmem_resp), 16'(w == 2));
    check("resp_pmem_rd", 16'(pmem_read),  16'd0);
    check("resp_pmem_wr", 16'(pmem_write), 16'd0);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 16'd1, 16'd0);
      got = 16'd0;
    end else got = exp_q.pop_front();
    check("rdata_i", imem_rdata, got);
    check("rdata_d", dmem_rdata, got);
    if (w == 1) imem_read = 1'b0;
    else begin dmem_read = 1'b0; dmem_write = 1'b0; end

    @(negedge clk);
    pmem_resp = 1'b0;
    check("hold_rdata", dmem_rdata, got);
  endtask

  logic pend_i, pend_d, r_dr, r_dw;
  logic [15:0] r_ia, r_da, r_wd;
  logic [1:0]  r_be;
  int w;

  initial begin
    reset_n = 1'b0;
    imem_read = 0; imem_address = 0; dmem_read = 0; dmem_write = 0;
    dmem_address = 0; dmem_wdata = 0; dmem_byte_enable = 0;
    pmem_resp = 0; pmem_rdata = 0;
    @(negedge clk); @(negedge clk);
    check_quiet("rst");
    check("rst_addr", pmem_address, 16'd0);
    check("rst_rdata", imem_rdata, 16'd0);
    check("rst_cnt", 16'(dbg_cnt), 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fetch with two wait states.
    do_round(1, 16'h0040, 0, 0, 16'h0, 16'h0, 2'b00, 2, 16'h1234, w);
    // Zero-wait byte write.
    do_round(0, 16'h0, 0, 1, 16'h0100, 16'hBEEF, 2'b01, 0, 16'h7777, w);
    // Simultaneous read/write: write wins.
    do_round(0, 16'h0, 1, 1, 16'h0300, 16'h00FF, 2'b10, 0, 16'h1111, w);
    // Both clients together: data first, fetch immediately after.
    do_round(1, 16'h0044, 1, 0, 16'h0500, 16'h0, 2'b00, 1, 16'h2222, w);
    do_round(1, 16'h0044, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h3333, w);

    // Fetch held while data re-requests every round: fetch must win every fifth.
    for (int i = 0; i < 12; i++) begin
      do_round(1, 16'h0080 + 16'(i), 1, 0, 16'h0600 + 16'(i), 16'h0, 2'b00,
               $urandom_range(0, 1), 16'($urandom), w);
    end

    // Reset in the middle of a data write; late pmem_resp must be ignored.
    do_round(0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00, 0, 16'h0, w);
    imem_read = 0; dmem_write = 1; dmem_address = 16'h0200;
    dmem_wdata = 16'h5555; dmem_byte_enable = 2'b11;
    @(negedge clk);
    check("pre_rst_wr", 16'(pmem_write), 16'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; dmem_write = 0;
    pmem_resp = 1'b1; pmem_rdata = 16'hABCD;
    check_quiet("mid_rst");
    check("mid_rst_addr",  pmem_address, 16'd0);
    check("mid_rst_wdata", pmem_wdata, 16'd0);
    check("mid_rst_be",    16'(pmem_byte_enable), 16'd0);
    check("mid_rst_state", 16'(dbg_state), 16'(IDLE));
    @(negedge clk);
    pmem_resp = 1'b0;
    check_quiet("post_rst");
    check("post_rst_rdata", dmem_rdata, 16'd0);
    m_cnt = 0;
    do_round(1, 16'h0900, 0, 0, 16'h0, 16'h0, 2'b00, 1, 16'h4321, w);

    // Randomized rounds; a losing request stays held unchanged.
    pend_i = 0; pend_d = 0;
    r_ia = 0; r_da = 0; r_wd = 0; r_be = 0; r_dr = 0; r_dw = 0;
    for (int n = 0; n < 200; n++) begin
      if (!pend_i && $urandom_range(0, 2) != 0) begin
        pend_i = 1; r_ia = 16'($urandom);
      end
      if (!pend_d && $urandom_range(0, 2) != 0) begin
        pend_d = 1;
        {r_dr, r_dw} = 2'($urandom_range(1, 3));
        r_da = 16'($urandom); r_wd = 16'($urandom); r_be = 2'($urandom);
      end
      do_round(pend_i, r_ia, pend_d & r_dr, pend_d & r_dw, r_da, r_wd, r_be,
               $urandom_range(0, 3), 16'($urandom), w);
      if (w == 1) pend_i = 0;
      if (w == 2) pend_d = 0;
    end

    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined LC-3b datapath.
- Accepts the datapath's word-wide instruction-fetch (imem) and data (dmem) requests and serialises them onto one shared physical-memory port (pmem) with variable-latency response.
- Data requests have priority; a starvation counter guarantees fetch progress.
- Each client sees a one-cycle resp pulse with registered read data.

Parameters:
STARVE_LIMIT, 4, max consecutive dmem grants while imem_read is pending before imem is forced to win (0 = imem always wins ties)
CNT_W, 3, starvation counter width; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous, active-low reset
imem_read  in  1  fetch request, held until imem_resp
imem_address  in  16  fetch word address
imem_rdata  out  16  fetch data, valid only with imem_resp
imem_resp  out  1  one-cycle completion pulse
dmem_read  in  1  data read request, held until dmem_resp
dmem_write  in  1  data write request, held until dmem_resp
dmem_address  in  16  data address
dmem_wdata  in  16  write data
dmem_byte_enable  in  2  lc3b_mem_wmask for writes
dmem_rdata  out  16  read data, valid only with dmem_resp
dmem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_address  out  16  physical address
pmem_wdata  out  16  physical write data
pmem_byte_enable  out  2  physical byte mask
pmem_rdata  in  16  physical read data, valid with pmem_resp
pmem_resp  in  1  physical completion, single cycle

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, starve_cnt=0, all capture registers=0.
  - All outputs 0, including both resp pulses and both rdata buses.
  - Applies mid-transaction: the outstanding access is abandoned, and a pmem_resp arriving afterwards is ignored.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE:
  - dreq = dmem_read|dmem_write.
  - If dreq and (!imem_read or starve_cnt<STARVE_LIMIT) -> SERVE_D.
  - Else if imem_read -> SERVE_I.
  - Else stay in IDLE.
  - pmem_resp is ignored in IDLE.
- Grant edge:
  - Capture address, wdata, byte_enable and op (read/write) into registers.
  - For an imem grant: op=read, mask=2'b11.
  - If dmem_read and dmem_write are both high: write wins, read ignored.
- Starvation counter, updated at the grant edge:
  - D grant with imem_read high: cnt+1, saturating.
  - D grant with imem_read low: cnt=0.
  - I grant: cnt=0.
- SERVE_x:
  - pmem_read or pmem_write is driven from the captured op.
  - pmem_address, pmem_wdata and pmem_byte_enable are driven from the capture registers.
  - Reads drive pmem_byte_enable=2'b11.
  - All stay stable until pmem_resp.
  - On pmem_resp: latch pmem_rdata into rdata_q and go to RESP_x. Strobes drop the cycle after pmem_resp.
- RESP_x:
  - Drive x_resp=1 for exactly one cycle.
  - Both imem_rdata and dmem_rdata are driven from rdata_q; only the resp'd client may sample.
  - The next state is always IDLE; no re-grant happens in RESP, even if requests are still high.
- Latency:
  - Request high at cycle 0 (IDLE) -> pmem strobe from cycle 1.
  - pmem_resp at cycle k -> client resp at cycle k+1.
  - Next arbitration happens at k+2.
  - Minimum 3 cycles per access with zero-wait pmem (pmem_resp in cycle 1).
- Client requests that drop before resp: the transaction still completes on pmem and resp still pulses. The client is out of spec.
- pmem_resp in RESP or IDLE: ignored.

Decomposition:
- Add an arb_state_t enum (the five states) to lc3b_types.
- Reuse lc3b_word and lc3b_mem_wmask from lc3b_types.
- Capture registers use the existing register #(width) module.
- No new sub-module; the FSM and counter stay inline.

Test Plan:
1. imem_read=1, addr=16'h0040; pmem_resp after 2 wait cycles with rdata=16'h1234 -> pmem_read held at addr 16'h0040 for 3 cycles; imem_resp single pulse the cycle after pmem_resp with imem_rdata=16'h1234; dmem_resp never asserts.
2. dmem_write=1, addr=16'h0100, wdata=16'hBEEF, be=2'b01, zero-wait pmem -> pmem_write=1 with those exact values; pmem_read=0 throughout; dmem_resp pulses once at cycle 2; back to IDLE at cycle 3.
3. imem_read and dmem_read asserted together -> dmem served first; imem served next with no idle gap beyond the RESP and IDLE cycles; each resp pulses exactly once.
4. STARVE_LIMIT=4; dmem re-requests immediately after each resp while imem_read stays high -> grant order D,D,D,D,I,D...; starve_cnt reads 4 before the I grant and 0 after it.
5. reset_n=0 for one cycle while in SERVE_D, then pmem_resp=1 -> all outputs 0 from the reset edge; pmem_resp ignored; no dmem_resp; a fresh imem request afterwards completes normally.
6. dmem_read=dmem_write=1, wdata=16'h00FF -> pmem_write=1, pmem_read=0, single dmem_resp.
